// File: rtl/coherence_bus_arbiter.sv
// Snooping coherence bus controller for NUM_CORES cores.
// Round-robin miss arbitration, snoop broadcast, copy-back or memory fill.
module coherence_bus_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CORES-1:0]        req_valid,
  input  logic [NUM_CORES-1:0]        req_write,
  input  logic [NUM_CORES*ADDR_W-1:0] req_addr,
  output logic [NUM_CORES-1:0]        grant,
  output logic [NUM_CORES-1:0]        stall,
  output logic                        snoop_valid,
  output logic [ADDR_W-1:0]           snoop_addr,
  output logic                        snoop_write,
  input  logic [NUM_CORES-1:0]        snoop_hit,
  input  logic [NUM_CORES-1:0]        snoop_dirty,
  input  logic [NUM_CORES*DATA_W-1:0] wb_data,
  output logic                        mem_rd,
  output logic                        mem_wr,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  input  logic                        mem_ack,
  output logic [NUM_CORES-1:0]        resp_valid,
  output logic [DATA_W-1:0]           resp_data,
  output logic                        resp_shared,
  output logic                        err_multi_dirty,
  output logic [15:0]                 c2c_count
);

  localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SNOOP    = 3'd1;
  localparam logic [2:0] S_COPYBACK = 3'd2;
  localparam logic [2:0] S_MEM_RD   = 3'd3;
  localparam logic [2:0] S_RESP     = 3'd4;

  logic [2:0]           state;
  logic [IW-1:0]        ptr;
  logic [IW-1:0]        idx;
  logic [ADDR_W-1:0]    addr_q;
  logic                 wr_q;
  logic                 shared_q;
  logic [DATA_W-1:0]    data_q;
  logic                 err_q;
  logic [15:0]          c2c_q;

  logic                 pick_any;
  logic [IW-1:0]        pick_idx;
  logic [NUM_CORES-1:0] req_bit;
  logic [NUM_CORES-1:0] oth_hit;
  logic [NUM_CORES-1:0] oth_dirty;
  logic [IW-1:0]        dsel;
  logic                 multi_dirty;
  logic [DATA_W-1:0]    wb_sel;

  assign req_bit   = NUM_CORES'(1) << idx;
  assign oth_hit   = snoop_hit & ~req_bit;
  assign oth_dirty = snoop_dirty & ~req_bit;
  assign multi_dirty =
    |(oth_dirty & (oth_dirty - NUM_CORES'(1)));
  assign wb_sel = wb_data[dsel*DATA_W +: DATA_W];

  // Round-robin pick: first requester at or after ptr, wrapping.
  always_comb begin : arb
    int j;
    pick_any = 1'b0;
    pick_idx = '0;
    j = 0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NUM_CORES) j -= NUM_CORES;
      if (req_valid[j]) begin
        pick_any = 1'b1;
        pick_idx = IW'(j);
      end
    end
  end

  // Lowest-index dirty snooper supplies the copy-back line.
  always_comb begin
    dsel = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (oth_dirty[i]) dsel = IW'(i);
    end
  end

  // Transaction sequencing and latched request context.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      ptr      <= '0;
      idx      <= '0;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      shared_q <= 1'b0;
      data_q   <= '0;
      err_q    <= 1'b0;
      c2c_q    <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (pick_any) begin
            idx    <= pick_idx;
            addr_q <= req_addr[pick_idx*ADDR_W +: ADDR_W];
            wr_q   <= req_write[pick_idx];
            state  <= S_SNOOP;
          end
        end
        S_SNOOP: begin
          shared_q <= (|oth_hit) & ~wr_q;
          if (multi_dirty) err_q <= 1'b1;
          if (|oth_dirty) begin
            data_q <= wb_sel;
            state  <= S_COPYBACK;
          end else begin
            state  <= S_MEM_RD;
          end
        end
        S_COPYBACK: begin
          if (mem_ack) begin
            if (c2c_q != 16'hFFFF) c2c_q <= c2c_q + 16'd1;
            state <= S_RESP;
          end
        end
        S_MEM_RD: begin
          if (mem_ack) begin
            data_q <= mem_rdata;
            state  <= S_RESP;
          end
        end
        S_RESP: begin
          ptr   <= (idx == IW'(NUM_CORES - 1)) ? '0 : idx + IW'(1);
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign grant       = (state != S_IDLE) ? req_bit : '0;
  assign snoop_valid = (state == S_SNOOP);
  assign snoop_addr  = snoop_valid ? addr_q : '0;
  assign snoop_write = snoop_valid & wr_q;
  assign mem_wr      = (state == S_COPYBACK);
  assign mem_rd      = (state == S_MEM_RD);
  assign mem_addr    = (mem_wr | mem_rd) ? addr_q : '0;
  assign mem_wdata   = mem_wr ? data_q : '0;
  assign resp_valid  = (state == S_RESP) ? req_bit : '0;
  assign resp_data   = (state == S_RESP) ? data_q : '0;
  assign resp_shared = (state == S_RESP) & shared_q;
  assign stall       = req_valid & ~resp_valid;
  assign err_multi_dirty = err_q;
  assign c2c_count   = c2c_q;

endmodule

// File: doc/coherence_bus_arbiter.md
Name: coherence_bus_arbiter

Overview:
- N-core snooping coherence bus controller. Generalises the two-core rd_intent/wr_intent/ex_or_shared/copy_back exchange to NUM_CORES cores.
- Arbitrates round-robin among core miss requests and broadcasts one snoop per transaction.
- Handles dirty copy-back with cache-to-cache forwarding, otherwise fetches from main memory.
- Returns data plus a shared/exclusive indication to the requester. Sits between the per-core pipelines and main memory.

Parameters:
NUM_CORES, 4, number of attached cores (2..8)
ADDR_W, 5, line address width
DATA_W, 32, line data width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req_valid  in  NUM_CORES  per-core bus request; held until that core's resp_valid
req_write  in  NUM_CORES  1 = wr_intent (read-for-ownership), 0 = rd_intent
req_addr  in  NUM_CORES*ADDR_W  per-core request address, core i at [i*ADDR_W +: ADDR_W]
grant  out  NUM_CORES  one-hot owner of the bus
stall  out  NUM_CORES  core waiting on the bus
snoop_valid  out  1  snoop broadcast strobe
snoop_addr  out  ADDR_W  snooped address
snoop_write  out  1  snoop is invalidating (requester has write intent)
snoop_hit  in  NUM_CORES  core holds snooped line (any valid state)
snoop_dirty  in  NUM_CORES  core holds snooped line modified (copy_back)
wb_data  in  NUM_CORES*DATA_W  dirty line data, valid with snoop_dirty
mem_rd  out  1  main memory read request
mem_wr  out  1  main memory write (copy-back)
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  copy-back data
mem_rdata  in  DATA_W  memory read data, valid with mem_ack
mem_ack  in  1  memory completes current mem_rd/mem_wr
resp_valid  out  NUM_CORES  one-hot single-cycle response
resp_data  out  DATA_W  line data for requester
resp_shared  out  1  1 = load shared, 0 = exclusive (ex_or_shared)
err_multi_dirty  out  1  sticky protocol error
c2c_count  out  16  saturating count of cache-to-cache transfers

Behaviour:
- Reset clears all state and outputs:
  - FSM goes to IDLE; round-robin pointer goes to 0.
  - grant, resp_valid, snoop_valid, mem_rd, mem_wr, err_multi_dirty and c2c_count are 0; data/address outputs are 0.
  - Reset mid-transaction aborts it; no response is issued.
- FSM states are IDLE, SNOOP, COPYBACK, MEM_RD, RESP.
- IDLE:
  - If any req_valid, pick the first set bit searching from ptr upward with wraparound.
  - Latch index, req_addr and req_write; go to SNOOP.
- SNOOP (one cycle):
  - snoop_valid=1, snoop_addr = latched address, snoop_write = latched write.
  - Sample snoop_hit/snoop_dirty masked by ~requester bit.
  - If any masked dirty: capture wb_data of the lowest-index dirty core; go to COPYBACK.
  - Otherwise go to MEM_RD.
  - If more than one masked dirty: set err_multi_dirty and still use the lowest index.
  - Latch shared = (any masked hit) & ~req_write.
- COPYBACK:
  - mem_wr=1, mem_addr = latched address, mem_wdata = captured data.
  - Hold until mem_ack, then go to RESP with resp_data = captured data.
  - c2c_count += 1, saturating at 0xFFFF.
- MEM_RD:
  - mem_rd=1 until mem_ack.
  - Capture mem_rdata on mem_ack; go to RESP.
- RESP (one cycle):
  - resp_valid = one-hot requester; resp_data and resp_shared driven.
  - ptr = requester+1, mod NUM_CORES. Go to IDLE.
- grant is one-hot to the requester from SNOOP through RESP inclusive; 0 in IDLE.
- stall[i] = req_valid[i] & ~resp_valid[i], combinational.
- Timing and handshakes:
  - mem_rd and mem_wr are never asserted together.
  - Minimum clean-miss latency: req seen in IDLE at cycle t, SNOOP t+1, MEM_RD t+2 with ack at t+2, resp_valid at t+3.
  - Next arbitration happens in IDLE at t+4.
- A requester dropping req_valid mid-transaction does not abort it; the response is still issued.
- Requests arriving while busy wait; there is no queueing beyond req_valid being held.
- Snooping cores invalidate on snoop_write and downgrade to shared on read; the cores own that. This block only reports state.

Test Plan:
- Single clean read: core 2 req addr 0x0A, no hits; mem_ack first MEM_RD cycle with rdata 0xDEADBEEF -> resp_valid=0b0100 at t+3, resp_data=0xDEADBEEF, resp_shared=0, mem_wr never asserted.
- Shared read: core 0 reads 0x03, snoop_hit=0b0010, no dirty -> resp_shared=1, data from memory.
- Dirty copy-back: core 1 write-intent 0x11, core 3 snoop_dirty with wb_data 0x12345678, mem_ack after 3 cycles -> snoop_write=1, mem_wr=1 with mem_wdata 0x12345678, no mem_rd, resp_data=0x12345678, resp_shared=0, c2c_count=1.
- Round-robin fairness: all four cores request continuously -> grant order 0,1,2,3,0; no core is granted twice before all others are served once.
- Self-hit masking and multi-dirty: requester's own snoop_dirty set -> ignored, goes to MEM_RD. Separately, two other cores dirty -> err_multi_dirty=1, data from the lower index.
- Reset in COPYBACK: assert reset while mem_wr=1 -> next cycle all outputs 0, state IDLE. A pending request is then re-arbitrated from core 0.
